data_mem_arbiter: RTL and testbench
===================================

// Module: data_mem_arbiter
// PURPOSE
//  Arbitrates the single-port data memory between two requesters: M0 = core load/store unit,
//  M1 = loader/debug port (bench or boot loader). Keeps program preload and data inspection
//  out of the core datapath.
//  Sits between core_inst/loader and mem_data_inst. Uses req/gnt handshake per master,
//  round-robin or fixed priority, and 1-cycle memory read latency.
// PARAMETERS
//  ADDR_W      10  word address width of data memory
//  FIXED_PRIO  0   1: M0 always wins ties; 0: round-robin
// PORTS
//  clk         in   1       single clock; all state on rising edge
//  rst         in   1       reset, asynchronous, active-high
//  mX_req      in   1       X=0,1: access request, held stable until mX_gnt seen
//  mX_we       in   1       1 = write, 0 = read
//  mX_be       in   4       byte enables (write only; bit i -> byte i)
//  mX_addr     in   ADDR_W  word address
//  mX_wdata    in   32      write data
//  mX_gnt      out  1       1-cycle pulse: request accepted, command on memory bus
//  mX_rvalid   out  1       1-cycle pulse: mX_rdata valid (reads only)
//  mX_rdata    out  32      read data (= mem_rdata; valid only with rvalid)
//  mem_en      out  1       memory command valid
//  mem_we      out  1       memory write strobe
//  mem_be      out  4       memory byte enables
//  mem_addr    out  ADDR_W  memory word address
//  mem_wdata   out  32      memory write data
//  mem_rdata   in   32      memory read data, valid 1 cycle after mem_en&&!mem_we
//  busy        out  1       state != IDLE
// BEHAVIOUR
//  Reset (async): state=IDLE, last_gnt=1 (M0 wins first tie), all outputs 0, latched cmd cleared.
//  FSM: IDLE, GRANT, RESP.
//   IDLE : if m0_req|m1_req -> choose winner, latch its we/be/addr/wdata, -> GRANT.
//   GRANT: mem_* driven from latched regs, mem_en=1; mW_gnt=1 for winner W; update last_gnt=W;
//          read -> RESP; write -> IDLE. Requests ignored in this cycle.
//   RESP : mW_rvalid=1, mW_rdata=mem_rdata; arbitrate as in IDLE: any req -> GRANT, else IDLE.
//  Winner: one req -> that master; both -> FIXED_PRIO ? M0 : ~last_gnt.
//  Timing: req sampled at edge ending cycle N -> gnt in N+1 -> rvalid in N+2.
//  Throughput: 1 access per 2 cycles, reads and writes alike.
//  Requester rule: drop req (or present a new command) in the cycle after gnt. The arbiter never
//  grants the same master in two consecutive GRANT cycles without an intervening IDLE/RESP sample.
//  All outputs come from registers (state, winner, latched cmd) only; no comb path req->mem_*.
//  mem_* = 0 outside GRANT; gnt/rvalid never asserted to both masters in one cycle.
//  rdata of the non-winning master = 0.
//  Address passes unchanged (no range check); be passes unchanged to memory on writes, 0 on reads.
//  Reset mid-operation: GRANT or RESP abandoned immediately; mem_en drops asynchronously;
//  no rvalid is issued after reset; requester re-issues.
//  Req dropped before gnt (protocol violation): the already latched command still executes.
// TESTING
//  1 M0 write addr 5 data 32'hA5A5_0F0F be 4'hF, then M0 read addr 5 -> gnt 1 cycle after req;
//    rvalid 2 cycles after req, rdata=A5A5_0F0F.
//  2 Out of reset, m0_req&m1_req held high, 4 reads -> grant order M0,M1,M0,M1;
//    each gnt 2 cycles apart.
//  3 FIXED_PRIO=1, both req held 6 cycles -> only M0 granted;
//    M1 granted first cycle after m0_req drops.
//  4 Word 3 = 32'h1122_3344; M1 write be 4'b0010 wdata 32'h0000_AB00 -> M0 read addr 3
//    returns 32'h1122_AB44.
//  5 M0 read; assert rst during GRANT -> mem_en=0 same cycle; state IDLE; no m0_rvalid;
//    busy=0 until next req after release.
//  6 M1 only, 8 back-to-back reads addrs 0..7 (preloaded i*4) -> gnt every 2 cycles;
//    rdata=0,4,..,28 in order; m0_* outputs stay 0.

Source files
------------

// File: rtl/data_mem_arbiter.sv
// Two-master arbiter for the single-port data memory.
// M0 is the core load/store unit and M1 is the loader/debug port. One access
// is issued every two cycles. All outputs are decoded from registered state,
// so there is no combinational path from any request to the memory bus.
module data_mem_arbiter #(
  parameter int ADDR_W     = 10,
  parameter int FIXED_PRIO = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic [3:0]        m0_be,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [31:0]       m0_wdata,
  output logic              m0_gnt,
  output logic              m0_rvalid,
  output logic [31:0]       m0_rdata,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic [3:0]        m1_be,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [31:0]       m1_wdata,
  output logic              m1_gnt,
  output logic              m1_rvalid,
  output logic [31:0]       m1_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [3:0]        mem_be,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  output logic              busy
);

  typedef enum logic [1:0] {IDLE = 2'd0, GRANT = 2'd1, RESP = 2'd2} state_t;

  state_t              state_q, state_d;
  logic                win_q, win_d;    // 0 = M0, 1 = M1
  logic                last_q, last_d;  // master granted most recently
  logic                we_q, we_d;
  logic [3:0]          be_q, be_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [31:0]         wdata_q, wdata_d;
  logic                any_req, arb_win, in_grant, in_resp;

  // Choose the winner among the requests currently presented
  always_comb begin
    any_req = m0_req | m1_req;
    if (m0_req && m1_req) arb_win = (FIXED_PRIO != 0) ? 1'b0 : ~last_q;
    else                  arb_win = m1_req;
  end

  // Next state, winner and latched command; requests are only looked at in IDLE/RESP
  always_comb begin
    state_d = state_q;
    win_d   = win_q;
    last_d  = last_q;
    we_d    = we_q;
    be_d    = be_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    case (state_q)
      GRANT: begin
        last_d  = win_q;
        state_d = we_q ? IDLE : RESP;
      end
      default: begin
        if (any_req) begin
          state_d = GRANT;
          win_d   = arb_win;
          we_d    = arb_win ? m1_we    : m0_we;
          be_d    = arb_win ? m1_be    : m0_be;
          addr_d  = arb_win ? m1_addr  : m0_addr;
          wdata_d = arb_win ? m1_wdata : m0_wdata;
        end else begin
          state_d = IDLE;
        end
      end
    endcase
  end

  // State and command registers; reset abandons any access in flight
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      win_q   <= 1'b0;
      last_q  <= 1'b1;
      we_q    <= 1'b0;
      be_q    <= 4'h0;
      addr_q  <= '0;
      wdata_q <= 32'h0;
    end else begin
      state_q <= state_d;
      win_q   <= win_d;
      last_q  <= last_d;
      we_q    <= we_d;
      be_q    <= be_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

  // Output decode from registered state; memory bus is zero outside GRANT
  always_comb begin
    in_grant  = (state_q == GRANT);
    in_resp   = (state_q == RESP);
    mem_en    = in_grant;
    mem_we    = in_grant & we_q;
    mem_be    = (in_grant && we_q) ? be_q : 4'h0;
    mem_addr  = in_grant ? addr_q : '0;
    mem_wdata = in_grant ? wdata_q : 32'h0;
    m0_gnt    = in_grant & ~win_q;
    m1_gnt    = in_grant &  win_q;
    m0_rvalid = in_resp & ~win_q;
    m1_rvalid = in_resp &  win_q;
    m0_rdata  = m0_rvalid ? mem_rdata : 32'h0;
    m1_rdata  = m1_rvalid ? mem_rdata : 32'h0;
    busy      = (state_q != IDLE);
  end

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Bench for data_mem_arbiter: directed scenarios followed by randomized
// traffic from two requesters, checked against a transaction-level model.
module tb_data_mem_arbiter;

  typedef struct packed {
    logic        req;
    logic        we;
    logic [3:0]  be;
    logic [9:0]  addr;
    logic [31:0] wd;
  } cmd_t;

  logic clk, rst;
  logic m0_req, m0_we, m1_req, m1_we;
  logic [3:0] m0_be, m1_be;
  logic [9:0] m0_addr, m1_addr;
  logic [31:0] m0_wdata, m1_wdata;
  logic m0_gnt, m0_rvalid, m1_gnt, m1_rvalid;
  logic [31:0] m0_rdata, m1_rdata;
  logic mem_en, mem_we, busy;
  logic [3:0] mem_be;
  logic [9:0] mem_addr;
  logic [31:0] mem_wdata, mem_rdata;

  logic fp_m0_gnt, fp_m0_rvalid, fp_m1_gnt, fp_m1_rvalid;
  logic [31:0] fp_m0_rdata, fp_m1_rdata;
  logic fp_mem_en, fp_mem_we, fp_busy;
  logic [3:0] fp_mem_be;
  logic [9:0] fp_mem_addr;
  logic [31:0] fp_mem_wdata;
  logic [31:0] fp_mem_rdata;

  logic [31:0] mem [0:1023];
  logic [31:0] ref_mem [0:1023];

  int vecs = 0;
  int miscompares = 0;

  data_mem_arbiter #(.ADDR_W(10), .FIXED_PRIO(0)) dut (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_we(m0_we), .m0_be(m0_be), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_be(m1_be), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy)
  );

  data_mem_arbiter #(.ADDR_W(10), .FIXED_PRIO(1)) dut_fp (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_we(m0_we), .m0_be(m0_be), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_gnt(fp_m0_gnt), .m0_rvalid(fp_m0_rvalid), .m0_rdata(fp_m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_be(m1_be), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_gnt(fp_m1_gnt), .m1_rvalid(fp_m1_rvalid), .m1_rdata(fp_m1_rdata),
    .mem_en(fp_mem_en), .mem_we(fp_mem_we), .mem_be(fp_mem_be), .mem_addr(fp_mem_addr),
    .mem_wdata(fp_mem_wdata), .mem_rdata(fp_mem_rdata), .busy(fp_busy)
  );

  assign fp_mem_rdata = 32'h0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Single-port memory with one cycle of read latency
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) begin
        for (int b = 0; b < 4; b++)
          if (mem_be[b]) mem[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
      end else begin
        mem_rdata <= mem[mem_addr];
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_bus(input string tag, input logic en, input logic we, input logic [3:0] be,
                         input logic [9:0] addr, input logic [31:0] wd);
    chk({tag, ".mem_en"}, mem_en, en);
    chk({tag, ".mem_we"}, mem_we, we);
    chk({tag, ".mem_be"}, mem_be, be);
    chk({tag, ".mem_addr"}, mem_addr, addr);
    chk({tag, ".mem_wdata"}, mem_wdata, wd);
  endtask

  task automatic drv(input int m, input logic req, input logic we, input logic [3:0] be,
                     input logic [9:0] addr, input logic [31:0] wd);
    if (m == 0) begin
      m0_req = req; m0_we = we; m0_be = be; m0_addr = addr; m0_wdata = wd;
    end else begin
      m1_req = req; m1_we = we; m1_be = be; m1_addr = addr; m1_wdata = wd;
    end
  endtask

  task automatic ref_write(input logic [9:0] a, input logic [31:0] d, input logic [3:0] be);
    for (int b = 0; b < 4; b++)
      if (be[b]) ref_mem[a][8*b +: 8] = d[8*b +: 8];
  endtask

  task automatic do_write(input int m, input logic [9:0] a, input logic [31:0] d, input logic [3:0] be);
    drv(m, 1'b1, 1'b1, be, a, d);
    step();
    chk("wr.gnt0", m0_gnt, (m == 0));
    chk("wr.gnt1", m1_gnt, (m == 1));
    chk_bus("wr", 1'b1, 1'b1, be, a, d);
    ref_write(a, d, be);
    drv(m, 1'b0, 1'b0, 4'h0, 10'h0, 32'h0);
    step();
    chk("wr.after.mem_en", mem_en, 1'b0);
    chk("wr.after.busy", busy, 1'b0);
  endtask

  task automatic do_read(input int m, input logic [9:0] a, input logic [31:0] exp);
    drv(m, 1'b1, 1'b0, 4'hF, a, 32'h0);
    step();
    chk("rd.gnt0", m0_gnt, (m == 0));
    chk("rd.gnt1", m1_gnt, (m == 1));
    chk_bus("rd", 1'b1, 1'b0, 4'h0, a, 32'h0);
    drv(m, 1'b0, 1'b0, 4'h0, 10'h0, 32'h0);
    step();
    chk("rd.rvalid0", m0_rvalid, (m == 0));
    chk("rd.rvalid1", m1_rvalid, (m == 1));
    chk("rd.rdata0", m0_rdata, (m == 0) ? exp : 32'h0);
    chk("rd.rdata1", m1_rdata, (m == 1) ? exp : 32'h0);
    chk("rd.resp.mem_en", mem_en, 1'b0);
  endtask

  cmd_t cur [2];
  cmd_t s0, s1, c;
  logic eg, ew, mlast, prev_g, rv_pend, rv_w;
  logic [31:0] rv_data;

  function automatic cmd_t rand_cmd();
    cmd_t r;
    r.req  = 1'b1;
    r.we   = 1'($urandom_range(0, 1));
    r.be   = 4'($urandom_range(0, 15));
    r.addr = 10'($urandom_range(0, 15));
    r.wd   = $urandom;
    return r;
  endfunction

  initial begin
    rst = 1'b1;
    drv(0, 1'b0, 1'b0, 4'h0, 10'h0, 32'h0);
    drv(1, 1'b0, 1'b0, 4'h0, 10'h0, 32'h0);
    #1;
    chk("reset.busy", busy, 1'b0);
    chk("reset.gnt", {m0_gnt, m1_gnt, m0_rvalid, m1_rvalid}, 4'h0);
    chk("reset.rdata", m0_rdata | m1_rdata, 32'h0);
    chk_bus("reset", 1'b0, 1'b0, 4'h0, 10'h0, 32'h0);
    step();
    rst = 1'b0;
    step();
    chk("idle.busy", busy, 1'b0);

    // write then read back through M0
    do_write(0, 10'd5, 32'hA5A5_0F0F, 4'hF);
    do_read(0, 10'd5, 32'hA5A5_0F0F);

    // byte-enable merge from M1 seen by M0
    do_write(0, 10'd3, 32'h1122_3344, 4'hF);
    do_write(1, 10'd3, 32'h0000_AB00, 4'b0010);
    do_read(0, 10'd3, 32'h1122_AB44);

    // M1 back-to-back reads of preloaded words
    for (int i = 0; i < 8; i++) do_write(1, 10'(i), 32'(i * 4), 4'hF);
    drv(1, 1'b1, 1'b0, 4'h0, 10'd0, 32'h0);
    for (int i = 0; i < 8; i++) begin
      step();
      chk("b2b.gnt1", m1_gnt, 1'b1);
      chk("b2b.addr", mem_addr, 32'(i));
      chk("b2b.gnt0", m0_gnt, 1'b0);
      if (i < 7) drv(1, 1'b1, 1'b0, 4'h0, 10'(i + 1), 32'h0);
      else       drv(1, 1'b0, 1'b0, 4'h0, 10'h0, 32'h0);
      step();
      chk("b2b.rvalid1", m1_rvalid, 1'b1);
      chk("b2b.rdata1", m1_rdata, 32'(i * 4));
      chk("b2b.m0", {m0_gnt, m0_rvalid, m1_gnt}, 3'b000);
      chk("b2b.rdata0", m0_rdata, 32'h0);
    end

    // reset during GRANT abandons the read
    drv(0, 1'b1, 1'b0, 4'h0, 10'd5, 32'h0);
    step();
    chk("rstmid.gnt0", m0_gnt, 1'b1);
    chk("rstmid.mem_en.pre", mem_en, 1'b1);
    rst = 1'b1;
    #1;
    chk("rstmid.mem_en", mem_en, 1'b0);
    chk("rstmid.busy", busy, 1'b0);
    chk("rstmid.gnt0.off", m0_gnt, 1'b0);
    drv(0, 1'b0, 1'b0, 4'h0, 10'h0, 32'h0);
    step();
    rst = 1'b0;
    step();
    chk("rstmid.no_rvalid", {m0_rvalid, m1_rvalid}, 2'b00);
    chk("rstmid.busy.after", busy, 1'b0);
    step();
    chk("rstmid.busy.after2", busy, 1'b0);
    do_read(0, 10'd5, ref_mem[5]);

    // both requesting out of reset: round-robin vs fixed priority
    rst = 1'b1;
    step();
    rst = 1'b0;
    drv(0, 1'b1, 1'b0, 4'h0, 10'd5, 32'h0);
    drv(1, 1'b1, 1'b0, 4'h0, 10'd3, 32'h0);
    for (int k = 0; k < 8; k++) begin
      step();
      chk("rr.gnt0", m0_gnt, (k == 0 || k == 4));
      chk("rr.gnt1", m1_gnt, (k == 2 || k == 6));
      chk("rr.rvalid0", m0_rvalid, (k == 1 || k == 5));
      chk("rr.rvalid1", m1_rvalid, (k == 3 || k == 7));
      chk("rr.rdata0", m0_rdata, (k == 1 || k == 5) ? ref_mem[5] : 32'h0);
      chk("rr.rdata1", m1_rdata, (k == 3 || k == 7) ? ref_mem[3] : 32'h0);
      chk("fp.gnt0", fp_m0_gnt, (k == 0 || k == 2 || k == 4));
      chk("fp.gnt1", fp_m1_gnt, (k == 6));
      chk("fp.mem_en", fp_mem_en, (k == 0 || k == 2 || k == 4 || k == 6));
      if (k == 5) drv(0, 1'b0, 1'b0, 4'h0, 10'h0, 32'h0);
      if (k == 6) drv(1, 1'b0, 1'b0, 4'h0, 10'h0, 32'h0);
    end
    step();

    // randomized traffic against a transaction-level model
    for (int i = 0; i < 16; i++) do_write(0, 10'(i), $urandom, 4'hF);
    mlast = 1'b0;
    prev_g = 1'b0;
    rv_pend = 1'b0;
    rv_w = 1'b0;
    rv_data = 32'h0;
    cur[0] = '0;
    cur[1] = '0;
    for (int it = 0; it < 600; it++) begin
      s0 = cur[0];
      s1 = cur[1];
      step();
      eg = !prev_g && (s0.req || s1.req);
      if (s0.req && s1.req) ew = ~mlast;
      else                  ew = s1.req;
      c = ew ? s1 : s0;
      chk("rnd.gnt0", m0_gnt, eg && !ew);
      chk("rnd.gnt1", m1_gnt, eg && ew);
      chk_bus("rnd", eg, eg && c.we, (eg && c.we) ? c.be : 4'h0,
              eg ? c.addr : 10'h0, eg ? c.wd : 32'h0);
      chk("rnd.rvalid0", m0_rvalid, rv_pend && !rv_w);
      chk("rnd.rvalid1", m1_rvalid, rv_pend && rv_w);
      chk("rnd.rdata0", m0_rdata, (rv_pend && !rv_w) ? rv_data : 32'h0);
      chk("rnd.rdata1", m1_rdata, (rv_pend && rv_w) ? rv_data : 32'h0);
      chk("rnd.busy", busy, eg || rv_pend);
      rv_pend = 1'b0;
      if (eg) begin
        mlast = ew;
        if (c.we) ref_write(c.addr, c.wd, c.be);
        else begin
          rv_pend = 1'b1;
          rv_w = ew;
          rv_data = ref_mem[c.addr];
        end
      end
      prev_g = eg;
      for (int m = 0; m < 2; m++) begin
        if (eg && (int'(ew) == m)) begin
          if ($urandom_range(0, 1) == 0) cur[m] = '0;
          else                           cur[m] = rand_cmd();
        end else if (!cur[m].req && $urandom_range(0, 2) == 0) begin
          cur[m] = rand_cmd();
        end
        drv(m, cur[m].req, cur[m].we, cur[m].be, cur[m].addr, cur[m].wd);
      end
    end
    drv(0, 1'b0, 1'b0, 4'h0, 10'h0, 32'h0);
    drv(1, 1'b0, 1'b0, 4'h0, 10'h0, 32'h0);
    step();
    step();
    step();
    chk("end.busy", busy, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, miscompares);
    $finish;
  end

endmodule
